// File: rtl/uart_pkg.sv
// Shared state encoding for the UART frame assembler.
// Pure declarations; no logic, no latency.
package uart_pkg;

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    WAIT_OP = 2'b10,
    HOLD    = 2'b11
  } state_t;

  // A frame is "in flight" once operand A has landed and until the opcode arrives.
  function automatic logic is_partial(input state_t s);
    return (s == WAIT_B) || (s == WAIT_OP);
  endfunction

endpackage

// File: rtl/pulse_edge_det.sv
// Rising-edge detector: one-cycle pulse when i_sig goes 0->1.
// Latency 0 (pulse is combinational from i_sig and registered history); no backpressure.
// History resets to 0, so a level already high when reset releases still yields one pulse.
module pulse_edge_det (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_pulse
);

  logic sig_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) sig_q <= 1'b0;
    else         sig_q <= i_sig;
  end

  assign o_pulse = i_sig & ~sig_q;

endmodule

// File: rtl/uart_frame_assembler.sv
// Collects three UART bytes (A, B, opcode) into one frame held until the consumer takes it.
// Latency: o_valid rises 1 cycle after the third byte; bytes arriving while the frame is held
// unacknowledged are dropped and flagged on o_overrun. Optional idle timeout: UART_FRAME_TIMEOUT_EN.
module uart_frame_assembler
  import uart_pkg::*;
#(
  parameter int DBIT        = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx_done,
  input  logic [DBIT-1:0] i_rx,
  input  logic            i_ready,
  output logic [DBIT-1:0] o_data_a,
  output logic [DBIT-1:0] o_data_b,
  output logic [DBIT-1:0] o_op,
  output logic            o_valid,
  output logic            o_overrun,
  output logic            o_busy
);

  if (TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t state, state_nxt;
  logic   rx_stb;
  logic   handshake;
  logic   timeout;

  pulse_edge_det u_rx_done_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_rx_done),
    .o_pulse (rx_stb)
  );

  assign handshake = o_valid & i_ready;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] idle_cnt;

  assign timeout = is_partial(state) && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                      idle_cnt <= '0;
    else if (!is_partial(state) || rx_stb || timeout) idle_cnt <= '0;
    else                                              idle_cnt <= idle_cnt + CNT_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_A:  if (rx_stb) state_nxt = WAIT_B;
      WAIT_B:  if (rx_stb) state_nxt = WAIT_OP; else if (timeout) state_nxt = WAIT_A;
      WAIT_OP: if (rx_stb) state_nxt = HOLD;    else if (timeout) state_nxt = WAIT_A;
      HOLD:    if (handshake) state_nxt = rx_stb ? WAIT_B : WAIT_A;
      default: state_nxt = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= WAIT_A;
      o_data_a  <= '0;
      o_data_b  <= '0;
      o_op      <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_valid <= (state_nxt == HOLD);
      o_busy  <= is_partial(state_nxt);

      if (rx_stb) begin
        case (state)
          WAIT_A:  o_data_a <= i_rx;
          WAIT_B:  o_data_b <= i_rx;
          WAIT_OP: o_op     <= i_rx;
          HOLD:    if (handshake) o_data_a <= i_rx;
          default: ;
        endcase
      end else if (timeout) begin
        o_data_a <= '0;
        o_data_b <= '0;
        o_op     <= '0;
      end

      // A byte landing on a handshake cycle is consumed as the next A, so it never overruns.
      if (handshake)                    o_overrun <= 1'b0;
      else if (rx_stb && state == HOLD) o_overrun <= 1'b1;
    end
  end

endmodule

// File: doc/uart_frame_assembler.md
UART_FRAME_ASSEMBLER -- requirements
Module: uart_frame_assembler

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning the width of the received data word.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1000000, meaning the idle clock cycles after which a partial frame is discarded (used only with the timeout feature).
REQ-003 The block SHALL have port i_clk, input, 1 bit, the single system clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit, the reset; it SHALL be asynchronous and active-high.
REQ-005 The block SHALL have port i_rx_done, input, 1 bit, the byte-complete flag from the UART receiver.
REQ-006 The block SHALL have port i_rx, input, DBIT bits, the received byte from the UART receiver.
REQ-007 The block SHALL have port i_ready, input, 1 bit, asserted by the consumer when it accepts a frame.
REQ-008 The block SHALL have ports o_data_a, o_data_b and o_op, each an output of DBIT bits, carrying frame operand A, operand B and the opcode.
REQ-009 The block SHALL have port o_valid, output, 1 bit, asserted while a complete frame is presented.
REQ-010 The block SHALL have port o_overrun, output, 1 bit, a sticky flag set when a byte is lost.
REQ-011 The block SHALL have port o_busy, output, 1 bit, asserted while a frame is partially received.

Function
REQ-012 A byte SHALL be accepted only on the rising edge of i_rx_done (i_rx_done=1 and the previous cycle's value=0), with i_rx sampled in that same cycle.
REQ-013 The state machine SHALL have four states: WAIT_A, WAIT_B, WAIT_OP and HOLD.
REQ-014 State transitions SHALL be: WAIT_A to WAIT_B on an accepted byte; WAIT_B to WAIT_OP on an accepted byte; WAIT_OP to HOLD on an accepted byte.
REQ-015 Accepted bytes SHALL be latched into o_data_a, o_data_b and o_op in that order.
REQ-016 o_valid SHALL be 1 exactly in HOLD, and SHALL assert on the cycle after the third byte is accepted (latency 1 cycle).
REQ-017 A handshake SHALL complete on a cycle with o_valid=1 and i_ready=1; the next state SHALL then be WAIT_A.
REQ-018 o_data_a, o_data_b and o_op SHALL remain stable while o_valid=1.
REQ-019 A byte accepted in HOLD without a handshake in the same cycle SHALL be dropped and SHALL set o_overrun.
REQ-020 A byte accepted in HOLD on the same cycle as a handshake SHALL be latched as operand A, with the next state WAIT_B and no overrun.
REQ-021 o_overrun SHALL clear on the cycle after the next completed handshake, unless an overrun occurs on that same handshake cycle.
REQ-022 o_busy SHALL be 1 in WAIT_B and WAIT_OP, and 0 otherwise.
REQ-023 i_ready SHALL be ignored outside HOLD.

Reset
REQ-024 While i_reset=1, the state SHALL be WAIT_A, all data outputs SHALL be 0, o_valid, o_overrun and o_busy SHALL be 0, and the i_rx_done edge history SHALL be 0.
REQ-025 A reset asserted mid-frame or in HOLD SHALL discard the frame immediately; no handshake SHALL be owed after reset.

Configuration
REQ-026 The timeout feature SHALL be compiled in only when macro UART_FRAME_TIMEOUT_EN is defined.
REQ-027 With UART_FRAME_TIMEOUT_EN defined:
- A counter of width ceil(log2(TIMEOUT_CYC+1)) SHALL run only in WAIT_B and WAIT_OP.
- The counter SHALL clear on each accepted byte.
- On reaching TIMEOUT_CYC-1, the next state SHALL be WAIT_A and the partial data SHALL be discarded.
- An accepted byte on that same cycle SHALL take priority and advance the state normally.
REQ-028 Without UART_FRAME_TIMEOUT_EN, no counter logic SHALL exist and a partial frame SHALL wait indefinitely.

Structure
REQ-029 State encodings (2-bit: WAIT_A=00, WAIT_B=01, WAIT_OP=10, HOLD=11) SHALL live in the shared package uart_pkg.
REQ-030 The i_rx_done rising-edge detection SHALL be the single sub-module pulse_edge_det (1-bit input, registered history, 1-bit pulse output).

Verification
REQ-031 Bench scenario: send bytes 0x12, 0x34, 0x20 with i_ready=1 -> o_valid asserts for one cycle with A=0x12, B=0x34, OP=0x20, and the state returns to WAIT_A.
REQ-032 Bench scenario: hold i_rx_done high for 5 cycles with i_rx=0xAA -> exactly one byte is accepted and o_busy=1.
REQ-033 Bench scenario: complete a frame with i_ready=0, then send 0x55 -> o_overrun=1 and the outputs keep the original frame; asserting i_ready clears o_overrun on the following cycle.
REQ-034 Bench scenario: in HOLD, a 0x77 byte edge coincides with i_ready=1 -> o_data_a=0x77, state WAIT_B, and o_overrun stays 0.
REQ-035 Bench scenario: assert i_reset after 2 bytes -> all outputs are 0 and a new 3-byte frame (0x01, 0x02, 0x03) is presented correctly.
REQ-036 Bench scenario: with UART_FRAME_TIMEOUT_EN and TIMEOUT_CYC=16, send 1 byte then idle 16 cycles -> o_busy drops to 0, and the next 3 bytes form a fresh frame.
